conv2_mac: RTL and testbench

//  Stage directly downstream of the conv2 3x3 window buffer. Consumes the nine-value window plus its valid

---
 rtl/conv2_pkg.sv | 22 ++
 rtl/conv2_mac_sat.sv | 37 +++
 rtl/conv2_mac.sv | 145 ++++++++++++++
 tb/tb_conv2_mac.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// Shared constants and types for the conv2 window buffer and MAC stage.
// Q-format defaults match the window buffer so both ends agree on scaling.
package conv2_pkg;

    localparam int         FILTER_TAPS   = 9;
    localparam logic [3:0] BIAS_IDX      = 4'd9;
    localparam int         COEF_NUM      = FILTER_TAPS + 1;

    localparam int         Q_DATA_BITS   = 32;
    localparam int         Q_WEIGHT_BITS = 16;
    localparam int         Q_FRAC_BITS   = 8;

    typedef logic signed [Q_WEIGHT_BITS-1:0] coef_t;

    localparam coef_t      Q_ONE = coef_t'(1 << Q_FRAC_BITS);

    // 9 products plus the bias need 4 extra bits; one spare for safety.
    function automatic int acc_bits(input int d, input int w);
        return d + w + 5;
    endfunction

endpackage

// File: rtl/conv2_mac_sat.sv
// Per-channel rescale and saturate of the MAC accumulator.
// CONV2_MAC_RELU_EN clamps negative results to zero.
module conv2_mac_sat #(
    parameter int ACC_BITS  = 53,
    parameter int DATA_BITS = 32,
    parameter int FRAC_BITS = 8
) (
    input  logic signed [ACC_BITS-1:0]  acc_i,
    output logic signed [DATA_BITS-1:0] res_o
);

    localparam logic signed [DATA_BITS-1:0] MAX_V = {1'b0, {(DATA_BITS-1){1'b1}}};
    localparam logic signed [DATA_BITS-1:0] MIN_V = {1'b1, {(DATA_BITS-1){1'b0}}};

    logic signed [ACC_BITS-1:0]  shifted;
    logic [ACC_BITS-DATA_BITS:0] top;
    logic                        fits;
    logic signed [DATA_BITS-1:0] sat;

    assign shifted = acc_i >>> FRAC_BITS;
    assign top     = shifted[ACC_BITS-1:DATA_BITS-1];
    assign fits    = (&top) || (~|top);

    always_comb begin
        sat = shifted[DATA_BITS-1:0];
        if (!fits) begin
            sat = shifted[ACC_BITS-1] ? MIN_V : MAX_V;
        end
    end

`ifdef CONV2_MAC_RELU_EN
    assign res_o = sat[DATA_BITS-1] ? '0 : sat;
`else
    assign res_o = sat;
`endif

endmodule

// File: rtl/conv2_mac.sv
// Four-stage OUT_CH x 3x3 convolution MAC with bias, saturation and frame count.
// Optional ReLU on the outputs via CONV2_MAC_RELU_EN.
module conv2_mac
    import conv2_pkg::*;
#(
    parameter  int WIDTH       = 15,
    parameter  int HEIGHT      = 19,
    parameter  int DATA_BITS   = Q_DATA_BITS,
    parameter  int WEIGHT_BITS = Q_WEIGHT_BITS,
    parameter  int FRAC_BITS   = Q_FRAC_BITS,
    parameter  int OUT_CH      = 3,
    localparam int CH_W        = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic signed [DATA_BITS-1:0]   data_in [0:FILTER_TAPS-1],
    input  logic                          w_we,
    input  logic [CH_W-1:0]               w_ch,
    input  logic [3:0]                    w_idx,
    input  logic signed [WEIGHT_BITS-1:0] w_data,
    output logic signed [DATA_BITS-1:0]   data_out [0:OUT_CH-1],
    output logic                          valid_out,
    output logic                          frame_done
);

    localparam int ACC_BITS  = acc_bits(DATA_BITS, WEIGHT_BITS);
    localparam int PROD_BITS = DATA_BITS + WEIGHT_BITS;
    localparam int FRAME_PIX = (WIDTH - 2) * (HEIGHT - 2);
    localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    logic signed [WEIGHT_BITS-1:0] coef_q  [OUT_CH][COEF_NUM];

    logic signed [PROD_BITS-1:0]   prod_d  [OUT_CH][FILTER_TAPS];
    logic signed [PROD_BITS-1:0]   prod_q  [OUT_CH][FILTER_TAPS];
    logic signed [WEIGHT_BITS-1:0] bias1_d [OUT_CH];
    logic signed [WEIGHT_BITS-1:0] bias1_q [OUT_CH];
    logic signed [WEIGHT_BITS-1:0] bias2_q [OUT_CH];
    logic signed [ACC_BITS-1:0]    row_d   [OUT_CH][3];
    logic signed [ACC_BITS-1:0]    row_q   [OUT_CH][3];
    logic signed [ACC_BITS-1:0]    acc_d   [OUT_CH];
    logic signed [ACC_BITS-1:0]    acc_q   [OUT_CH];
    logic signed [DATA_BITS-1:0]   sat_res [OUT_CH];
    logic signed [DATA_BITS-1:0]   out_q   [OUT_CH];

    logic             v1_q, v2_q, v3_q, vo_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             fd_d, fd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < OUT_CH; c++) begin
                for (int k = 0; k < COEF_NUM; k++) begin
                    coef_q[c][k] <= '0;
                end
            end
        end else if (w_we && (int'(w_ch) < OUT_CH) && (w_idx <= BIAS_IDX)) begin
            coef_q[w_ch][w_idx] <= w_data;
        end
    end

    always_comb begin
        for (int c = 0; c < OUT_CH; c++) begin
            for (int k = 0; k < FILTER_TAPS; k++) begin
                prod_d[c][k] = PROD_BITS'(data_in[k]) * PROD_BITS'(coef_q[c][k]);
            end
            bias1_d[c] = coef_q[c][BIAS_IDX];
            for (int r = 0; r < 3; r++) begin
                row_d[c][r] = ACC_BITS'(prod_q[c][3*r])
                            + ACC_BITS'(prod_q[c][3*r+1])
                            + ACC_BITS'(prod_q[c][3*r+2]);
            end
            acc_d[c] = row_q[c][0] + row_q[c][1] + row_q[c][2]
                     + (ACC_BITS'(bias2_q[c]) <<< FRAC_BITS);
        end
    end

    // Bias travels with its window so a mid-stream write stays coherent.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            prod_q  <= prod_d;
            bias1_q <= bias1_d;
        end
        if (v1_q) begin
            row_q   <= row_d;
            bias2_q <= bias1_q;
        end
        if (v2_q) begin
            acc_q   <= acc_d;
        end
    end

    for (genvar g = 0; g < OUT_CH; g++) begin : g_sat
        conv2_mac_sat #(
            .ACC_BITS  (ACC_BITS),
            .DATA_BITS (DATA_BITS),
            .FRAC_BITS (FRAC_BITS)
        ) u_sat (
            .acc_i (acc_q[g]),
            .res_o (sat_res[g])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        fd_d  = 1'b0;
        if (v3_q) begin
            if (cnt_q == CNT_W'(FRAME_PIX - 1)) begin
                cnt_d = '0;
                fd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            vo_q  <= 1'b0;
            fd_q  <= 1'b0;
            cnt_q <= '0;
            for (int c = 0; c < OUT_CH; c++) begin
                out_q[c] <= '0;
            end
        end else begin
            v1_q  <= valid_in;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            vo_q  <= v3_q;
            fd_q  <= fd_d;
            cnt_q <= cnt_d;
            if (v3_q) begin
                out_q <= sat_res;
            end
        end
    end

    assign data_out   = out_q;
    assign valid_out  = vo_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_conv2_mac.sv
// Directed bench for conv2_mac: latency, MAC math, saturation, weight timing,
// frame counting and mid-frame reset.
module tb_conv2_mac;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid_in;
    logic signed [31:0] din [0:8];
    logic               w_we;
    logic [1:0]         w_ch;
    logic [3:0]         w_idx;
    logic signed [15:0] w_data;
    logic signed [31:0] dout [0:2];
    logic               valid_out;
    logic               frame_done;

    int total = 0;
    int bad   = 0;
    int nout  = 0;
    int nfd   = 0;
    bit mon   = 1'b0;

    always #5 clk = ~clk;

    conv2_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (din),
        .w_we       (w_we),
        .w_ch       (w_ch),
        .w_idx      (w_idx),
        .w_data     (w_data),
        .data_out   (dout),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon) begin
            if (frame_done === 1'b1) nfd++;
            if (valid_out === 1'b1) begin
                nout++;
                chk("fdone_at_out", 32'(frame_done), 32'(nout == 221));
            end
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [3:0] idx,
                      input logic signed [15:0] val);
        w_we   = 1'b1;
        w_ch   = ch;
        w_idx  = idx;
        w_data = val;
        tick();
        w_we   = 1'b0;
    endtask

    task automatic setd(input logic signed [31:0] v);
        for (int i = 0; i < 9; i++) din[i] = v;
    endtask

    task automatic win();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        chk("lat_early", 32'(valid_out), 32'd0);
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        w_we     = 1'b0;
        w_ch     = '0;
        w_idx    = '0;
        w_data   = '0;
        setd(0);
        repeat (3) tick();
        chk("rst_vo", 32'(valid_out), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_d0", dout[0], 32'd0);
        chk("rst_d2", dout[2], 32'd0);
        rst_n = 1'b1;
        tick();

        wr(2'd0, 4'd4, 16'sd256);
        din[4] = 32'h500;
        win();
        chk("id_vo", 32'(valid_out), 32'd1);
        chk("id_d0", dout[0], 32'h500);
        tick();
        chk("id_vo_pulse", 32'(valid_out), 32'd0);
        chk("id_hold", dout[0], 32'h500);

        for (int k = 0; k < 9; k++) wr(2'd1, 4'(k), 16'sd256);
        setd(256);
        win();
        chk("box_d1", dout[1], 32'd2304);
        chk("box_d0", dout[0], 32'd256);
        wr(2'd1, 4'd9, 16'sd256);
        wr(2'd3, 4'd9, 16'sh4000);
        wr(2'd1, 4'd12, 16'sh4000);
        setd(0);
        win();
        chk("bias_d1", dout[1], 32'd256);
        chk("bias_d0", dout[0], 32'd0);

        for (int k = 0; k < 9; k++) wr(2'd2, 4'(k), 16'sh7FFF);
        setd(32'sh7FFF_FFFF);
        win();
        chk("satp_d2", dout[2], 32'h7FFF_FFFF);
        chk("satp_d1", dout[1], 32'h7FFF_FFFF);
        for (int k = 0; k < 9; k++) wr(2'd2, 4'(k), 16'sh8000);
        win();
`ifdef CONV2_MAC_RELU_EN
        chk("satn_d2", dout[2], 32'h0);
`else
        chk("satn_d2", dout[2], 32'h8000_0000);
`endif

        setd(0);
        din[4]   = 32'sd256;
        w_we     = 1'b1;
        w_ch     = 2'd0;
        w_idx    = 4'd4;
        w_data   = 16'sd512;
        valid_in = 1'b1;
        tick();
        w_we = 1'b0;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        chk("wt_vo1", 32'(valid_out), 32'd1);
        chk("wt_old", dout[0], 32'd256);
        chk("wt_d1", dout[1], 32'd512);
        tick();
        chk("wt_vo2", 32'(valid_out), 32'd1);
        chk("wt_new", dout[0], 32'd512);
        tick();
        chk("wt_vo3", 32'(valid_out), 32'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mon  = 1'b1;
        nout = 0;
        nfd  = 0;
        for (int i = 0; i < 222; i++) begin
            setd($urandom_range(0, 1000));
            valid_in = 1'b1;
            tick();
            valid_in = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (6) tick();
        mon = 1'b0;
        chk("frm_nout", nout, 32'd222);
        chk("frm_nfd", nfd, 32'd1);
        chk("frm_wcleared", dout[0], 32'd0);

        wr(2'd0, 4'd4, 16'sd256);
        setd(256);
        valid_in = 1'b1;
        repeat (3) tick();
        valid_in = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_vo", 32'(valid_out), 32'd0);
        chk("mr_d0", dout[0], 32'd0);
        chk("mr_d1", dout[1], 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_no_vo", 32'(valid_out), 32'd0);
        end
        win();
        chk("mr_vo_w", 32'(valid_out), 32'd1);
        chk("mr_wzero", dout[0], 32'd0);
        mon  = 1'b1;
        nout = 1;
        nfd  = 0;
        valid_in = 1'b1;
        repeat (221) tick();
        valid_in = 1'b0;
        repeat (6) tick();
        mon = 1'b0;
        chk("mr_nout", nout, 32'd222);
        chk("mr_nfd", nfd, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
